recorder: RTL and testbench
===========================

RECORDER -- requirements
Module: recorder

Interface
REQ-001 Parameter DEPTH, default 16384: sample memory depth in 8-bit words; power of two.
REQ-002 Parameter AW, default 14: address width, equals log2(DEPTH).
REQ-003 clk_in  input  1  sole clock; all logic rising-edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 record_in  input  1  level; high = capture audio, low = play back last capture.
REQ-006 audio_valid_in  input  1  one-cycle sample strobe (nominal 12 kHz); paces both capture and playback.
REQ-007 audio_in  input  8  signed microphone sample, sampled only when audio_valid_in=1.
REQ-008 single_out  output  8  signed played-back sample, registered.
REQ-009 finish  output  1  registered; high while a valid recording is being played back.
REQ-010 recording_length  output  32  present only with RECORDER_LENGTH_OUT_EN; captured sample count, zero-extended.

Function
REQ-011 Three-state FSM: IDLE, RECORD, PLAY.
REQ-012 IDLE: record_in=1 -> RECORD, write address and sample count cleared to 0 on that edge.
REQ-013 RECORD: each cycle with audio_valid_in=1 writes audio_in to mem[waddr], waddr+1, count+1.
REQ-014 RECORD full: at count=DEPTH, further strobes ignored, no wrap, no overwrite; count saturates at DEPTH.
REQ-015 RECORD: record_in=0 -> PLAY if count>0, else IDLE; read address cleared to 0.
REQ-016 Strobe coincident with record_in falling edge: not written.
REQ-017 PLAY: memory read synchronously every cycle at raddr; single_out <= read data, so single_out shows mem[raddr] two cycles after raddr changes.
REQ-018 PLAY: each audio_valid_in=1 advances raddr; raddr=count-1 wraps to 0; playback loops until record_in rises.
REQ-019 PLAY: record_in=1 -> RECORD; finish drops on same edge; new capture overwrites from address 0.
REQ-020 finish=1 exactly in PLAY (asserted on entry edge); 0 in IDLE and RECORD.
REQ-021 single_out=0 in IDLE and RECORD; holds last value between strobes in PLAY.
REQ-022 Memory infers single-port-write/single-port-read block RAM; contents not cleared by reset.

Reset
REQ-023 rst_in=1 at clock edge: state IDLE, waddr/raddr/count=0, single_out=0, finish=0; overrides record_in and audio_valid_in.
REQ-024 Reset mid-RECORD or mid-PLAY aborts; count=0, so record_in low after reset stays IDLE.
REQ-025 Reset with record_in held high: IDLE, then RECORD on the next edge.

Configuration
REQ-026 Macro RECORDER_LENGTH_OUT_EN defined: recording_length port exists, equals count, updates in RECORD, holds in PLAY, 0 after reset.
REQ-027 Macro undefined: recording_length port and its logic absent; all other behaviour identical.

Verification
REQ-028 Reset then record_in=1, audio_valid_in=1 for 100 cycles, audio_in=i -> count=100, finish=0, single_out=0 throughout.
REQ-029 After REQ-028, record_in=0, one strobe every 7 cycles -> finish=1 next edge; single_out sequence 0,1,...,99,0,1 (wrap checked).
REQ-030 Record DEPTH+10 strobes -> count=DEPTH; playback of index 0 returns first sample, not sample DEPTH.
REQ-031 record_in pulsed high 3 cycles, no strobes -> returns to IDLE, finish never asserts.
REQ-032 rst_in=1 for one cycle during PLAY -> next edge finish=0, single_out=0, state IDLE with record_in=0.
REQ-033 record_in re-asserted in PLAY, 5 new samples 0x80..0x84 -> finish=0; playback then loops 0x80..0x84 only.

Source files
------------

// File: rtl/recorder.sv
// recorder: captures 8-bit audio samples into a block RAM, then loops playback of the last capture.
// Optional recording_length output is enabled by defining RECORDER_LENGTH_OUT_EN.
module recorder #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              record_in,
  input  logic              audio_valid_in,
  input  logic signed [7:0] audio_in,
  output logic signed [7:0] single_out,
  output logic              finish
`ifdef RECORDER_LENGTH_OUT_EN
  ,
  output logic [31:0]       recording_length
`endif
);

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  state_t            state;
  logic [AW:0]       count;
  logic [AW-1:0]     raddr;
  logic signed [7:0] rdata;
  logic              full;
  logic              wr_en;
  logic              last;

  logic signed [7:0] mem [DEPTH];

  // The write address is the sample count itself; it never exceeds DEPTH-1 while writing.
  assign full  = (count == DEPTH_C);
  assign wr_en = !rst_in && (state == RECORD) && record_in && audio_valid_in && !full;
  assign last  = ({1'b0, raddr} == count - 1'b1);

  // NOTE: RAM contents are deliberately left out of reset so the array maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[count[AW-1:0]] <= audio_in;
    rdata <= mem[raddr];
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      count      <= '0;
      raddr      <= '0;
      single_out <= '0;
      finish     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          raddr      <= '0;
          single_out <= '0;
          finish     <= 1'b0;
          if (record_in) begin
            state <= RECORD;
            count <= '0;
          end
        end
        RECORD: begin
          // raddr parked at 0 so the RAM already presents sample 0 when playback starts.
          raddr      <= '0;
          single_out <= '0;
          if (!record_in) begin
            if (count != '0) begin
              state  <= PLAY;
              finish <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (audio_valid_in && !full) begin
            count <= count + 1'b1;
          end
        end
        PLAY: begin
          if (record_in) begin
            state      <= RECORD;
            count      <= '0;
            raddr      <= '0;
            single_out <= '0;
            finish     <= 1'b0;
          end else begin
            single_out <= rdata;
            if (audio_valid_in) raddr <= last ? '0 : raddr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RECORDER_LENGTH_OUT_EN
  assign recording_length = 32'(count);
`endif

endmodule

// File: tb/tb_recorder.sv
// tb_recorder: randomized scoreboard bench for recorder against a queue-based capture/playback model.
module tb_recorder;

  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       record_in;
  logic       audio_valid_in;
  logic [7:0] audio_in;
  logic [7:0] single_out;
  logic       finish;
`ifdef RECORDER_LENGTH_OUT_EN
  logic [31:0] recording_length;
`endif

  always #5 clk_in = ~clk_in;

  recorder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .record_in      (record_in),
    .audio_valid_in (audio_valid_in),
    .audio_in       (audio_in),
    .single_out     (single_out),
    .finish         (finish)
`ifdef RECORDER_LENGTH_OUT_EN
    ,
    .recording_length (recording_length)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the capture is a queue of samples, playback is an index into it.
  typedef enum {M_IDLE, M_RECORD, M_PLAY} mstate_t;
  mstate_t    mstate = M_IDLE;
  logic [7:0] rec[$];
  int         idx = 0;
  logic [7:0] expq[$];
  bit         armed = 1'b0;

  task automatic step(input bit r, input bit rec_i, input bit v, input logic [7:0] d);
    rst_in         = r;
    record_in      = rec_i;
    audio_valid_in = v;
    audio_in       = d;
    // The sample on display just before an advancing strobe is the current playback index.
    if (!r && mstate == M_PLAY && !rec_i && v) expq.push_back(rec[idx]);
    @(posedge clk_in);
    if (r) begin
      mstate = M_IDLE;
      rec.delete();
    end else begin
      case (mstate)
        M_IDLE: if (rec_i) begin mstate = M_RECORD; rec.delete(); end
        M_RECORD: begin
          if (!rec_i) begin
            if (rec.size() > 0) mstate = M_PLAY;
            else                mstate = M_IDLE;
            idx = 0;
          end else if (v && rec.size() < DEPTH) begin
            rec.push_back(d);
          end
        end
        M_PLAY: begin
          if (rec_i) begin
            mstate = M_RECORD;
            rec.delete();
          end else if (v) begin
            idx = (idx + 1) % rec.size();
          end
        end
        default: mstate = M_IDLE;
      endcase
    end
    #1;
  endtask

  task automatic idle_steps(input int n, input bit rec_i);
    for (int i = 0; i < n; i++) step(1'b0, rec_i, 1'b0, 8'h00);
  endtask

  task automatic play_strobes(input int n, input int gap_lo, input int gap_hi);
    for (int i = 0; i < n; i++) begin
      idle_steps($urandom_range(gap_hi, gap_lo) - 1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 8'($urandom));
    end
  endtask

  // Monitor: per-cycle status checks plus scoreboard pops whenever the DUT is playing and strobed.
  always @(negedge clk_in) begin
    if (armed) begin
      check("finish", {31'b0, finish}, {31'b0, mstate == M_PLAY});
      if (mstate != M_PLAY) check("single_out_idle", {24'b0, single_out}, 32'h0);
`ifdef RECORDER_LENGTH_OUT_EN
      check("recording_length", recording_length, rec.size());
`endif
      if (audio_valid_in && finish && !record_in && !rst_in) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL playback_underflow: got strobe with empty queue, expected no playback at %0t", $time);
        end else begin
          check("playback_sample", {24'b0, single_out}, {24'b0, expq.pop_front()});
        end
      end
    end
  end

  initial begin
    // Reset with record_in held high: IDLE first, RECORD on the following edge.
    step(1'b1, 1'b1, 1'b1, 8'h55);
    armed = 1'b1;
    check("rst_finish", {31'b0, finish}, 32'h0);
    check("rst_single_out", {24'b0, single_out}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Capture 0..99 back-to-back, then play with a strobe every 7 cycles past the wrap.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1, 8'(i));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("play_entry_finish", {31'b0, finish}, 32'h1);
    play_strobes(103, 7, 7);

    // Re-record in PLAY with five samples 0x80..0x84; playback loops only those.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("rerecord_finish", {31'b0, finish}, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h80 + i));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    play_strobes(12, 3, 6);

    // Reset during PLAY, then stay idle with record_in low.
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check("rst_play_finish", {31'b0, finish}, 32'h0);
    check("rst_play_single_out", {24'b0, single_out}, 32'h0);
    idle_steps(4, 1'b0);

    // record_in pulsed three cycles without strobes falls back to IDLE.
    idle_steps(3, 1'b1);
    idle_steps(4, 1'b0);

    // Overfill: DEPTH+10 strobes saturate; playback index 0 returns the first sample.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH + 10; i++) step(1'b0, 1'b1, 1'b1, 8'(i + 3));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    play_strobes(DEPTH + 3, 3, 4);

    // Random rounds: sparse capture, strobe on the falling record edge, random pacing, random resets.
    for (int r = 0; r < 8; r++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < int'($urandom_range(40, 1)); i++)
        step(1'b0, 1'b1, 1'($urandom_range(1, 0)), 8'($urandom));
      step(1'b0, 1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
      play_strobes($urandom_range(30, 5), 3, 9);
      if ($urandom_range(3, 0) == 0) begin
        step(1'b1, 1'($urandom_range(1, 0)), 1'b1, 8'h00);
        idle_steps(2, 1'b0);
      end
    end

    idle_steps(3, 1'b0);
    check("scoreboard_drained", expq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
